// File: rtl/mem_cmd_issuer.sv
// mem_cmd_issuer: single-bank DRAM command initiator (controller side).
// Accepts read/write requests through a one-entry holding register and issues
// one-cycle ACT/RD/RDA/WR/WRA/PR/REF pulses at the earliest legal cycle.
// The open row is kept between requests, and refresh is scheduled from a
// free-running interval timer.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready = holding register empty)
//   req_we, req_ap        write select, auto-precharge select
//   req_row, req_col      request address
//   T_RCD..T_RFC          8-bit timing values in cycles (0 behaves as 1)
//   T_REFI                16-bit refresh interval
//   ACT..REF              command pulses, at most one high per cycle
//   cmd_row, cmd_col      address that accompanies ACT / column commands
//   row_open, open_row    bank row status
module mem_cmd_issuer #(
  parameter int ROWW = 14,
  parameter int COLW = 10,
  parameter int BL   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic            req_ap,
  input  logic [ROWW-1:0] req_row,
  input  logic [COLW-1:0] req_col,
  input  logic [7:0]      T_RCD,
  input  logic [7:0]      T_RAS,
  input  logic [7:0]      T_RP,
  input  logic [7:0]      T_RTP,
  input  logic [7:0]      T_WR,
  input  logic [7:0]      T_RFC,
  input  logic [15:0]     T_REFI,
  output logic            ACT,
  output logic            RD,
  output logic            RDA,
  output logic            WR,
  output logic            WRA,
  output logic            PR,
  output logic            REF,
  output logic [ROWW-1:0] cmd_row,
  output logic [COLW-1:0] cmd_col,
  output logic            row_open,
  output logic [ROWW-1:0] open_row
);

  localparam int CW = (BL > 1) ? $clog2(BL) : 1;
  localparam logic [CW-1:0] BL_M1 = CW'(BL - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ACTIVATING  = 3'd1,
    S_OPEN        = 3'd2,
    S_PRECHARGING = 3'd3,
    S_APR         = 3'd4,
    S_REFRESHING  = 3'd5
  } state_t;

  // Counters hold "cycles still to wait"; a counter is satisfied at zero.
  // A command at t loads T-1 so the dependent command may go at t+T.
  function automatic logic [7:0] tm1(input logic [7:0] t);
    return (t == 8'd0) ? 8'd0 : (t - 8'd1);
  endfunction

  function automatic logic [7:0] dec8(input logic [7:0] c);
    return (c == 8'd0) ? 8'd0 : (c - 8'd1);
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t          state_r, state_nxt_s;
  logic            held_r, h_we_r, h_ap_r;
  logic [ROWW-1:0] h_row_r, open_row_r;
  logic [COLW-1:0] h_col_r;
  logic [7:0]      rcd_r, pr_r, act_r;
  logic [CW-1:0]   col_r;
  logic [15:0]     refi_r, refi_eff_s;
  logic            ref_pend_r, row_open_r, refi_exp_s;
  logic            act_s, rd_s, rda_s, wr_s, wra_s, pr_s, ref_s, col_s, apr_pre_s;
  logic            rcd_ok_s, pr_ok_s, act_ok_s, col_ok_s, hit_s;
  logic [7:0]      pr_load_s, act_load_s;

  assign rcd_ok_s   = (rcd_r == 8'd0);
  assign pr_ok_s    = (pr_r == 8'd0);
  assign act_ok_s   = (act_r == 8'd0);
  assign col_ok_s   = (col_r == {CW{1'b0}});
  assign hit_s      = held_r && (h_row_r == open_row_r);
  assign col_s      = rd_s | rda_s | wr_s | wra_s;
  assign refi_eff_s = (T_REFI == 16'd0) ? 16'd1 : T_REFI;
  assign refi_exp_s = (refi_r <= 16'd1);

  // Command decision and next state from the registered bank state.
  always_comb begin
    state_nxt_s = state_r;
    act_s = 1'b0; rd_s = 1'b0; rda_s = 1'b0; wr_s = 1'b0;
    wra_s = 1'b0; pr_s = 1'b0; ref_s = 1'b0; apr_pre_s = 1'b0;
    case (state_r)
      // PRECHARGING/REFRESHING fall into IDLE behaviour the cycle tRP/tRFC is met.
      S_IDLE, S_PRECHARGING, S_REFRESHING: begin
        if (act_ok_s) begin
          if (ref_pend_r) begin
            ref_s = 1'b1;
            state_nxt_s = S_REFRESHING;
          end else if (held_r) begin
            act_s = 1'b1;
            state_nxt_s = S_ACTIVATING;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      // ACTIVATING behaves as OPEN from the cycle tRCD is met.
      S_ACTIVATING, S_OPEN: begin
        if (rcd_ok_s) begin
          state_nxt_s = S_OPEN;
          if (ref_pend_r || (held_r && !hit_s)) begin
            if (pr_ok_s) begin
              pr_s = 1'b1;
              state_nxt_s = S_PRECHARGING;
            end else begin
              pr_s = 1'b0;
            end
          end else if (held_r && col_ok_s) begin
            if (h_ap_r) begin
              rda_s = ~h_we_r;
              wra_s = h_we_r;
              state_nxt_s = S_APR;
            end else begin
              rd_s = ~h_we_r;
              wr_s = h_we_r;
            end
          end else begin
            state_nxt_s = S_OPEN;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      // Internal precharge happens the cycle all precharge constraints are met.
      S_APR: begin
        if (pr_ok_s) begin
          apr_pre_s = 1'b1;
          state_nxt_s = S_PRECHARGING;
        end else begin
          state_nxt_s = S_APR;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Constraint loads contributed by the command issued this cycle.
  always_comb begin
    pr_load_s  = 8'd0;
    act_load_s = 8'd0;
    if (act_s) begin
      pr_load_s = tm1(T_RAS);
    end else if (rd_s || rda_s) begin
      pr_load_s = tm1(T_RTP);
    end else if (wr_s || wra_s) begin
      pr_load_s = tm1(T_WR);
    end else begin
      pr_load_s = 8'd0;
    end
    if (pr_s || apr_pre_s) begin
      act_load_s = tm1(T_RP);
    end else if (ref_s) begin
      act_load_s = tm1(T_RFC);
    end else begin
      act_load_s = 8'd0;
    end
  end

  assign ACT       = act_s;
  assign RD        = rd_s;
  assign RDA       = rda_s;
  assign WR        = wr_s;
  assign WRA       = wra_s;
  assign PR        = pr_s;
  assign REF       = ref_s;
  assign cmd_row   = act_s ? h_row_r : {ROWW{1'b0}};
  assign cmd_col   = col_s ? h_col_r : {COLW{1'b0}};
  assign req_ready = ~held_r;
  assign row_open  = row_open_r;
  assign open_row  = open_row_r;

  // State register and request holding register (freed by its column command).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      held_r  <= 1'b0;
      h_we_r  <= 1'b0;
      h_ap_r  <= 1'b0;
      h_row_r <= {ROWW{1'b0}};
      h_col_r <= {COLW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (col_s) begin
        held_r <= 1'b0;
      end else if (req_valid && !held_r) begin
        held_r  <= 1'b1;
        h_we_r  <= req_we;
        h_ap_r  <= req_ap;
        h_row_r <= req_row;
        h_col_r <= req_col;
      end
    end
  end

  // Timing counters; pr/act keep the larger of the pending and new constraint.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcd_r <= 8'd0;
      pr_r  <= 8'd0;
      act_r <= 8'd0;
      col_r <= {CW{1'b0}};
    end else begin
      rcd_r <= act_s ? tm1(T_RCD) : dec8(rcd_r);
      pr_r  <= max8(dec8(pr_r), pr_load_s);
      act_r <= max8(dec8(act_r), act_load_s);
      if (col_s) begin
        col_r <= BL_M1;
      end else if (col_r != {CW{1'b0}}) begin
        col_r <= col_r - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Refresh interval timer; an expiry while already pending is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refi_r     <= refi_eff_s;
      ref_pend_r <= 1'b0;
    end else begin
      refi_r <= refi_exp_s ? refi_eff_s : (refi_r - 16'd1);
      if (ref_s) begin
        ref_pend_r <= 1'b0;
      end else if (refi_exp_s) begin
        ref_pend_r <= 1'b1;
      end
    end
  end

  // Open-row tracking; auto-precharge commands close the row immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_open_r <= 1'b0;
      open_row_r <= {ROWW{1'b0}};
    end else if (act_s) begin
      row_open_r <= 1'b1;
      open_row_r <= h_row_r;
    end else if (pr_s || rda_s || wra_s) begin
      row_open_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_cmd_issuer.sv
// Directed bench for mem_cmd_issuer. Cycle 0 is the cycle in which reset is
// released; commands are logged with their cycle number on the falling edge.
module tb_mem_cmd_issuer;
  localparam int ROWW = 14;
  localparam int COLW = 10;
  localparam int BL   = 8;
  localparam int K_ACT = 0, K_RD = 1, K_RDA = 2, K_WR = 3, K_WRA = 4, K_PR = 5, K_REF = 6;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_we, req_ap;
  logic [ROWW-1:0] req_row, cmd_row, open_row;
  logic [COLW-1:0] req_col, cmd_col;
  logic [7:0] T_RCD, T_RAS, T_RP, T_RTP, T_WR, T_RFC;
  logic [15:0] T_REFI;
  logic ACT, RD, RDA, WR, WRA, PR, REF, row_open;

  int tests = 0;
  int fails = 0;
  int clk_cnt = 0;
  int base = 0;
  int pulse_n;
  int ev_cyc[$];
  int ev_kind[$];
  int ev_addr[$];

  mem_cmd_issuer #(.ROWW(ROWW), .COLW(COLW), .BL(BL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_ap(req_ap), .req_row(req_row), .req_col(req_col),
    .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP), .T_RTP(T_RTP), .T_WR(T_WR),
    .T_RFC(T_RFC), .T_REFI(T_REFI),
    .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .PR(PR), .REF(REF),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .row_open(row_open), .open_row(open_row)
  );

  always #5 clk = ~clk;

  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  // Command logger plus per-cycle protocol checks.
  always @(negedge clk) begin
    if (!rst) begin
      pulse_n = $countones({ACT, RD, RDA, WR, WRA, PR, REF});
      tests++;
      if (pulse_n > 1) begin
        fails++;
        $display("FAIL one_hot cyc=%0d got %0d pulses, required <= 1", clk_cnt - base, pulse_n);
      end
      tests++;
      if ((RD || RDA || WR || WRA) && !row_open) begin
        fails++;
        $display("FAIL col_closed cyc=%0d column command with row_open=0, required row_open=1", clk_cnt - base);
      end
      tests++;
      if ((ACT || REF) && row_open) begin
        fails++;
        $display("FAIL act_open cyc=%0d ACT/REF with row_open=1, required row_open=0", clk_cnt - base);
      end
      if (pulse_n > 0) begin
        ev_cyc.push_back(clk_cnt - base);
        ev_kind.push_back(ACT ? K_ACT : RD ? K_RD : RDA ? K_RDA : WR ? K_WR :
                          WRA ? K_WRA : PR ? K_PR : K_REF);
        ev_addr.push_back(ACT ? int'(cmd_row) : (RD || RDA || WR || WRA) ? int'(cmd_col) : 0);
      end
    end
  end

  function automatic int find_ev(input int kind, input int nth);
    int seen = 0;
    for (int i = 0; i < ev_kind.size(); i++) begin
      if (ev_kind[i] == kind) begin
        if (seen == nth) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic int count_ev(input int kind);
    int n = 0;
    for (int i = 0; i < ev_kind.size(); i++) if (ev_kind[i] == kind) n++;
    return n;
  endfunction

  task automatic set_defaults();
    T_RCD = 8'd3; T_RAS = 8'd8; T_RP = 8'd3; T_RTP = 8'd2;
    T_WR = 8'd4; T_RFC = 8'd10; T_REFI = 16'd1000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base = clk_cnt;
    ev_cyc.delete();
    ev_kind.delete();
    ev_addr.delete();
  endtask

  task automatic wait_cyc(input int c);
    while ((clk_cnt - base) < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request for exactly cycle c.
  task automatic send(input int c, input logic we, input logic ap, input int row, input int col);
    wait_cyc(c);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready cyc=%0d req_ready=%b, required 1", c, req_ready);
    end
    req_valid = 1'b1;
    req_we = we;
    req_ap = ap;
    req_row = ROWW'(row);
    req_col = COLW'(col);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic check_ev(input string name, input int kind, input int nth, input int cyc, input int addr);
    int idx;
    idx = find_ev(kind, nth);
    tests++;
    if (idx < 0) begin
      fails++;
      $display("FAIL %s missing, required at cycle %0d", name, cyc);
    end else if (ev_cyc[idx] !== cyc || ev_addr[idx] !== addr) begin
      fails++;
      $display("FAIL %s got cycle %0d addr 0x%0h, required cycle %0d addr 0x%0h",
               name, ev_cyc[idx], ev_addr[idx], cyc, addr);
    end
  endtask

  task automatic test_reset();
    set_defaults();
    req_valid = 1'b0; req_we = 1'b0; req_ap = 1'b0; req_row = '0; req_col = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ACT, RD, RDA, WR, WRA, PR, REF} !== 7'b0) begin
      fails++; $display("FAIL reset_pulses got %b, required 0", {ACT, RD, RDA, WR, WRA, PR, REF});
    end
    tests++;
    if (req_ready !== 1'b1 || row_open !== 1'b0) begin
      fails++; $display("FAIL reset_flags got ready=%b row_open=%b, required 1 0", req_ready, row_open);
    end
    tests++;
    if (open_row !== '0 || cmd_row !== '0 || cmd_col !== '0) begin
      fails++; $display("FAIL reset_addr got open_row=%0h cmd_row=%0h cmd_col=%0h, required 0", open_row, cmd_row, cmd_col);
    end
  endtask

  task automatic test_read_first();
    do_reset();
    send(0, 1'b0, 1'b0, 5, 'h10);
    tests++;
    if (req_ready !== 1'b0) begin
      fails++; $display("FAIL ready_c1 got %b, required 0", req_ready);
    end
    wait_cyc(4);
    tests++;
    if (req_ready !== 1'b0 || row_open !== 1'b1 || open_row !== 14'd5) begin
      fails++; $display("FAIL open_c4 got ready=%b row_open=%b open_row=%0d, required 0 1 5", req_ready, row_open, open_row);
    end
    wait_cyc(5);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL ready_c5 got %b, required 1", req_ready);
    end
    check_ev("t1_act", K_ACT, 0, 1, 5);
    check_ev("t1_rd", K_RD, 0, 4, 'h10);
  endtask

  task automatic test_back_to_back();
    send(5, 1'b0, 1'b0, 5, 'h20);
    wait_cyc(13);
    check_ev("t2_rd", K_RD, 1, 12, 'h20);
    tests++;
    if (count_ev(K_ACT) !== 1 || count_ev(K_PR) !== 0) begin
      fails++; $display("FAIL t2_no_act_pr got ACT=%0d PR=%0d, required 1 0", count_ev(K_ACT), count_ev(K_PR));
    end
  endtask

  task automatic test_row_miss();
    send(13, 1'b0, 1'b0, 9, 'h30);
    wait_cyc(15);
    tests++;
    if (row_open !== 1'b0) begin
      fails++; $display("FAIL t3_closed got row_open=%b, required 0", row_open);
    end
    wait_cyc(21);
    check_ev("t3_pr", K_PR, 0, 14, 0);
    check_ev("t3_act", K_ACT, 1, 17, 9);
    check_ev("t3_rd", K_RD, 2, 20, 'h30);
    tests++;
    if (row_open !== 1'b1 || open_row !== 14'd9) begin
      fails++; $display("FAIL t3_open got row_open=%b open_row=%0d, required 1 9", row_open, open_row);
    end
  endtask

  task automatic test_write_ap();
    do_reset();
    send(0, 1'b1, 1'b1, 2, 'h44);
    wait_cyc(5);
    tests++;
    if (row_open !== 1'b0) begin
      fails++; $display("FAIL t4_closed got row_open=%b, required 0", row_open);
    end
    send(5, 1'b0, 1'b0, 2, 'h8);
    wait_cyc(17);
    check_ev("t4_act0", K_ACT, 0, 1, 2);
    check_ev("t4_wra", K_WRA, 0, 4, 'h44);
    check_ev("t4_act1", K_ACT, 1, 12, 2);
    check_ev("t4_rd", K_RD, 0, 15, 'h8);
    tests++;
    if (count_ev(K_PR) !== 0) begin
      fails++; $display("FAIL t4_no_pr got %0d PR, required 0", count_ev(K_PR));
    end
  endtask

  task automatic test_refresh();
    set_defaults();
    T_REFI = 16'd20;
    do_reset();
    send(0, 1'b0, 1'b0, 5, 'h1);
    send(19, 1'b0, 1'b0, 5, 'h2);
    wait_cyc(38);
    check_ev("t5_pr", K_PR, 0, 20, 0);
    check_ev("t5_ref", K_REF, 0, 23, 0);
    check_ev("t5_act", K_ACT, 1, 33, 5);
    check_ev("t5_rd", K_RD, 1, 36, 'h2);
    tests++;
    if (count_ev(K_REF) !== 1) begin
      fails++; $display("FAIL t5_ref_count got %0d, required 1", count_ev(K_REF));
    end
    set_defaults();
  endtask

  task automatic test_async_reset();
    do_reset();
    send(0, 1'b0, 1'b0, 7, 'h3);
    wait_cyc(2);
    tests++;
    if (row_open !== 1'b1) begin
      fails++; $display("FAIL t6_pre got row_open=%b, required 1", row_open);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b1 || row_open !== 1'b0 || open_row !== '0 ||
        {ACT, RD, RDA, WR, WRA, PR, REF} !== 7'b0) begin
      fails++; $display("FAIL t6_async got ready=%b row_open=%b open_row=%0d pulses=%b, required 1 0 0 0",
                        req_ready, row_open, open_row, {ACT, RD, RDA, WR, WRA, PR, REF});
    end
    do_reset();
    wait_cyc(8);
    tests++;
    if (ev_cyc.size() !== 0) begin
      fails++; $display("FAIL t6_dropped got %0d commands, required 0", ev_cyc.size());
    end
    send(8, 1'b0, 1'b0, 4, 'h5);
    wait_cyc(14);
    check_ev("t6_act", K_ACT, 0, 9, 4);
    check_ev("t6_rd", K_RD, 0, 12, 'h5);
  endtask

  initial begin
    test_reset();
    test_read_first();
    test_back_to_back();
    test_row_miss();
    test_write_ap();
    test_refresh();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
